// File: rtl/core_pkg.sv
// Shared types for the RV32I core pipeline control: operand widths, forwarding
// select encoding and hazard sequencer states.
package core_pkg;
  typedef logic [31:0] data32_t;
  typedef logic [4:0]  data5_t;
  typedef logic [1:0]  data2_t;

  typedef enum logic [1:0] {FWD_REG = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_sel_e;
  typedef enum logic {HZ_RUN = 1'b0, HZ_STALL = 1'b1} hz_state_e;

  localparam data5_t REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Combinational EX operand forwarding selects and ID register-read bypass.
// A loading instruction in MEM has no data yet, so it never forwards from MEM.
module forward_unit
  import core_pkg::*;
(
  input  data5_t rs1_ex,
  input  data5_t rs2_ex,
  input  data5_t rs1_id,
  input  data5_t rs2_id,
  input  data5_t rd_mem,
  input  logic   load_mem,
  input  logic   im_to_rf_mem,
  input  data5_t rd_wb,
  input  logic   im_to_rf_wb,
  output data2_t forward_a_sel,
  output data2_t forward_b_sel,
  output logic   bypass_rs1_id,
  output logic   bypass_rs2_id
);
  logic mem_wr, wb_wr;

  assign mem_wr = im_to_rf_mem & ~load_mem & (rd_mem != REG_ZERO);
  assign wb_wr  = im_to_rf_wb & (rd_wb != REG_ZERO);

  function automatic data2_t sel_of(input data5_t rs, input logic m, input logic w,
                                    input data5_t rdm, input data5_t rdw);
    fwd_sel_e s;
    s = FWD_REG;
    if (m && rdm == rs)      s = FWD_MEM;
    else if (w && rdw == rs) s = FWD_WB;
    return data2_t'(s);
  endfunction

  assign forward_a_sel = sel_of(rs1_ex, mem_wr, wb_wr, rd_mem, rd_wb);
  assign forward_b_sel = sel_of(rs2_ex, mem_wr, wb_wr, rd_mem, rd_wb);
  assign bypass_rs1_id = wb_wr & (rd_wb == rs1_id);
  assign bypass_rs2_id = wb_wr & (rd_wb == rs2_id);
endmodule

// File: rtl/hazard_controller.sv
// 5-stage pipeline sequencer: load-use stalls, MEM-resolved redirect flushes,
// forwarding selects. HAZARD_PERF_CNT_EN enables stall/flush performance counters.
module hazard_controller
  import core_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int XLEN              = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_id,
  input  logic [4:0]      rs2_id,
  input  logic [4:0]      rs1_ex,
  input  logic [4:0]      rs2_ex,
  input  logic [4:0]      rd_ex,
  input  logic            load_ex,
  input  logic            im_to_rf_ex,
  input  logic [4:0]      rd_mem,
  input  logic            load_mem,
  input  logic            im_to_rf_mem,
  input  logic [4:0]      rd_wb,
  input  logic            im_to_rf_wb,
  input  logic            redirect_mem,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic [1:0]      forward_a_sel,
  output logic [1:0]      forward_b_sel,
  output logic            bypass_rs1_id,
  output logic            bypass_rs2_id,
  output logic [XLEN-1:0] stall_count,
  output logic [XLEN-1:0] flush_count
);
  // First stall cycle happens in RUN, so STALL covers the remaining ones.
  localparam logic [2:0] CNT_INIT = (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
  localparam bit MULTI = (LOAD_STALL_CYCLES > 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       load_use;
  data2_t     fa, fb;
  logic       b1, b2;

  assign load_use = load_ex & im_to_rf_ex & (rd_ex != REG_ZERO) &
                    ((rd_ex == rs1_id) | (rd_ex == rs2_id));

  forward_unit u_fwd (
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_mem(rd_mem), .load_mem(load_mem), .im_to_rf_mem(im_to_rf_mem),
    .rd_wb(rd_wb), .im_to_rf_wb(im_to_rf_wb),
    .forward_a_sel(fa), .forward_b_sel(fb),
    .bypass_rs1_id(b1), .bypass_rs2_id(b2)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    forward_a_sel = fa;
    forward_b_sel = fb;
    bypass_rs1_id = b1;
    bypass_rs2_id = b2;
    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      forward_a_sel = 2'd0;
      forward_b_sel = 2'd0;
      bypass_rs1_id = 1'b0;
      bypass_rs2_id = 1'b0;
      state_d       = HZ_RUN;
      cnt_d         = 3'd0;
    end else if (redirect_mem) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = HZ_RUN;
    end else if (state_q == HZ_STALL) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      if (cnt_q == 3'd0) state_d = HZ_RUN;
      else               cnt_d   = cnt_q - 3'd1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      if (MULTI) begin
        state_d = HZ_STALL;
        cnt_d   = CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en)       stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_mem) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Directed checks of hazard_controller with LOAD_STALL_CYCLES=1 (u1) and 3 (u3).
module tb_hazard_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic load_ex, im_to_rf_ex, load_mem, im_to_rf_mem, im_to_rf_wb, redirect_mem;

  logic pc1, ifen1, iff1, idf1, exf1, bp11, bp21;
  logic [1:0] fa1, fb1;
  logic [31:0] sc1, fc1;
  logic pc3, ifen3, iff3, idf3, exf3, bp13, bp23;
  logic [1:0] fa3, fb3;
  logic [31:0] sc3, fc3;

  int n_chk = 0;
  int n_fail = 0;

  hazard_controller #(.LOAD_STALL_CYCLES(1), .XLEN(32)) u1 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .load_ex(load_ex), .im_to_rf_ex(im_to_rf_ex),
    .rd_mem(rd_mem), .load_mem(load_mem), .im_to_rf_mem(im_to_rf_mem),
    .rd_wb(rd_wb), .im_to_rf_wb(im_to_rf_wb), .redirect_mem(redirect_mem),
    .pc_en(pc1), .if_id_en(ifen1), .if_id_flush(iff1), .id_ex_flush(idf1), .ex_mem_flush(exf1),
    .forward_a_sel(fa1), .forward_b_sel(fb1), .bypass_rs1_id(bp11), .bypass_rs2_id(bp21),
    .stall_count(sc1), .flush_count(fc1));

  hazard_controller #(.LOAD_STALL_CYCLES(3), .XLEN(32)) u3 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .load_ex(load_ex), .im_to_rf_ex(im_to_rf_ex),
    .rd_mem(rd_mem), .load_mem(load_mem), .im_to_rf_mem(im_to_rf_mem),
    .rd_wb(rd_wb), .im_to_rf_wb(im_to_rf_wb), .redirect_mem(redirect_mem),
    .pc_en(pc3), .if_id_en(ifen3), .if_id_flush(iff3), .id_ex_flush(idf3), .ex_mem_flush(exf3),
    .forward_a_sel(fa3), .forward_b_sel(fb3), .bypass_rs1_id(bp13), .bypass_rs2_id(bp23),
    .stall_count(sc3), .flush_count(fc3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    load_ex = 0; im_to_rf_ex = 0; load_mem = 0; im_to_rf_mem = 0; im_to_rf_wb = 0;
    redirect_mem = 0;
  endtask

  // lw x5 in EX, consumer of x5 in ID
  task automatic set_load_use();
    rd_ex = 5; load_ex = 1; im_to_rf_ex = 1; rs1_id = 5; rs2_id = 1;
  endtask

  initial begin
    clr();
    rst = 1;
    rd_mem = 3; im_to_rf_mem = 1; rs1_ex = 3;
    step(); step();
    chk("rst_pc_en", pc1, 0);
    chk("rst_if_id_en", ifen1, 0);
    chk("rst_flushes", {iff1, idf1, exf1}, 3'b111);
    chk("rst_fwd_a", fa1, 0);
    chk("rst_cnt", {sc1, fc1}, 0);

    rst = 0; clr(); #1;
    chk("run_pc_en", {pc1, ifen1, pc3}, 3'b111);
    chk("run_flushes", {iff1, idf1, exf1}, 0);
    step();

    // load-use, cycle 1
    set_load_use(); #1;
    chk("lu_u1_pc_en", {pc1, ifen1}, 0);
    chk("lu_u1_flush", {iff1, idf1, exf1}, 3'b010);
    chk("lu_u3_pc_en", pc3, 0);
    step();
    // lw in MEM, bubble in EX
    clr(); rd_mem = 5; load_mem = 1; im_to_rf_mem = 1; rs1_id = 5; rs2_id = 1; #1;
    chk("lu_u1_resume", pc1, 1);
    chk("lu_u3_stall2", {pc3, idf3}, 2'b01);
    step();
    // lw in WB, add x6,x5,x1 in EX
    clr(); rd_wb = 5; im_to_rf_wb = 1; rs1_ex = 5; rs2_ex = 1; rs1_id = 5; rs2_id = 2; #1;
    chk("lu_fwd_a_wb", fa1, 2);
    chk("lu_fwd_b_reg", fb1, 0);
    chk("bypass_rs1", {bp11, bp21}, 2'b10);
    chk("lu_u3_stall3", pc3, 0);
    step();
    clr(); #1;
    chk("lu_u3_back_run", {pc3, ifen3, idf3}, 3'b110);

    // MEM forwarding both operands, and x0 suppression
    rd_mem = 3; im_to_rf_mem = 1; rs1_ex = 3; rs2_ex = 3; #1;
    chk("fwd_mem_ab", {fa1, fb1}, 4'b0101);
    rd_mem = 0; rs1_ex = 0; rs2_ex = 0; #1;
    chk("fwd_x0_ab", {fa1, fb1}, 0);
    rd_wb = 0; im_to_rf_wb = 1; rs1_id = 0; #1;
    chk("bypass_x0", bp11, 0);

    // MEM beats WB; loading MEM falls back to WB
    clr(); rd_mem = 7; rd_wb = 7; im_to_rf_mem = 1; im_to_rf_wb = 1; rs2_ex = 7; #1;
    chk("fwd_b_mem_prio", {fa1, fb1}, 4'b0001);
    load_mem = 1; #1;
    chk("fwd_b_load_wb", fb1, 2);
    step();

    // redirect beats load-use
    clr(); set_load_use(); redirect_mem = 1; #1;
    chk("redir_u1", {pc1, ifen1, iff1, idf1, exf1}, 5'b11111);
    chk("redir_u3", {pc3, ifen3, iff3, idf3, exf3}, 5'b11111);
    step();
    clr(); #1;
    chk("redir_u3_run", pc3, 1);
    step();

    // redirect on 2nd stall cycle of u3
    set_load_use(); #1;
    step();
    clr(); #1;
    chk("rs_u3_stall2", pc3, 0);
    redirect_mem = 1; #1;
    chk("rs_u3_redir", {pc3, ifen3, iff3, idf3, exf3}, 5'b11111);
    step();
    clr(); #1;
    chk("rs_u3_run", pc3, 1);
    step();

    // reset mid-stall
    set_load_use(); #1;
    step();
    clr(); rst = 1;
    step();
    rst = 0; #1;
    chk("rst_mid_stall", pc3, 1);
    step();

    // 4 stall cycles and 2 redirects on u1
    set_load_use();
    repeat (4) step();
    clr(); redirect_mem = 1;
    repeat (2) step();
    clr(); #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_count", sc1, 4);
    chk("flush_count", fc1, 2);
`else
    chk("stall_count_off", sc1, 0);
    chk("flush_count_off", fc1, 0);
`endif
    rst = 1;
    step();
    chk("cnt_after_rst", {sc1, fc1}, 0);
    rst = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Detects load-use and control hazards, drives stage enables/flushes for program_counter, if_id, id_ex and ex_mem, and drives operand-forwarding selects for the EX operand muxes and ID register-read bypass.
- Branch/jump redirect resolves in MEM (next_pc muxed there); load data is available at WB.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7; >1 for slow data memory).
- XLEN, 32, data width (counter width only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs1_id, rs2_id  in  5  source registers of instruction in ID
- rs1_ex, rs2_ex  in  5  source registers of instruction in EX
- rd_ex  in  5;  load_ex  in  1;  im_to_rf_ex  in  1
- rd_mem  in  5;  load_mem  in  1;  im_to_rf_mem  in  1
- rd_wb  in  5;  im_to_rf_wb  in  1
- redirect_mem  in  1  taken branch / jal / jalr in MEM (next_pc != pc_plus_4_mem)
- pc_en  out  1  program_counter update enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load NOP (all controls 0, rd 0)
- forward_a_sel, forward_b_sel  out  2  0 = rs_data_ex, 1 = alu_data_mem, 2 = register_file_data (WB)
- bypass_rs1_id, bypass_rs2_id  out  1  ID read takes register_file_data
- stall_count, flush_count  out  XLEN  performance counters (see Optional Feature)

Behaviour:
- FSM states RUN, STALL; 3-bit down-counter cnt. Reset: state RUN, cnt 0, counters 0.
- Outputs are combinational from state and inputs. During rst: pc_en=0, if_id_en=0, all flushes=1, selects/bypasses 0.
- load_use = load_ex & im_to_rf_ex & rd_ex!=0 & (rd_ex==rs1_id | rd_ex==rs2_id).
- RUN, redirect_mem=1:
  - if_id_flush, id_ex_flush and ex_mem_flush all =1; pc_en=1, if_id_en=1.
  - Stay in RUN. Redirect has priority over load_use.
- RUN, load_use, no redirect:
  - pc_en=0, if_id_en=0, id_ex_flush=1.
  - If LOAD_STALL_CYCLES>1: cnt<=LOAD_STALL_CYCLES-2 and go to STALL; else stay in RUN.
- RUN, otherwise: pc_en=1, if_id_en=1, no flushes.
- STALL:
  - Same outputs as a load_use stall.
  - If cnt==0, go to RUN; else cnt decrements.
  - redirect_mem in STALL takes redirect outputs, aborts the stall and goes to RUN. The stalled ID instruction is flushed.
- Forwarding, operand A (B is identical using rs2_ex):
  - sel=1 if im_to_rf_mem & !load_mem & rd_mem!=0 & rd_mem==rs1_ex.
  - Else sel=2 if im_to_rf_wb & rd_wb!=0 & rd_wb==rs1_ex.
  - Else sel=0. MEM beats WB when both match.
- bypass_rsN_id = im_to_rf_wb & rd_wb!=0 & rd_wb==rsN_id. Evaluated while stalled too.
- x0 never forwarded or bypassed. Both sources matching the same rd both forward.
- rst mid-stall returns to RUN next cycle, counters cleared.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_count increments each cycle pc_en=0 outside reset.
  - flush_count increments each cycle redirect_mem=1 outside reset.
  - Both wrap at 2^XLEN.
- Undefined: both outputs tied to 0, no counter flops.

Decomposition:
- Package core_pkg holds:
  - typedefs data32_t, data5_t, data2_t;
  - enum fwd_sel_e {FWD_REG, FWD_MEM, FWD_WB};
  - enum hz_state_e {HZ_RUN, HZ_STALL};
  - localparam REG_ZERO = 5'd0.
- One sub-module, forward_unit: purely combinational forwarding and bypass logic, instantiated once.

Test Plan:
- lw x5 in EX, add x6,x5,x1 in ID, LOAD_STALL_CYCLES=1 -> one cycle pc_en=0, id_ex_flush=1. Two cycles later add reaches EX with forward_a_sel=2.
- add x3 in MEM, sub x4,x3,x3 in EX -> forward_a_sel=1 and forward_b_sel=1. Same with rd_mem=0 -> both 0.
- rd_mem=rd_wb=x7=rs2_ex -> forward_b_sel=1. With load_mem=1 -> 2.
- redirect_mem=1 while load_use=1 -> three flushes=1, pc_en=1, state stays RUN.
- LOAD_STALL_CYCLES=3, load_use -> pc_en low exactly 3 cycles. Redirect on 2nd stall cycle -> flushes asserted, FSM back to RUN next cycle.
- HAZARD_PERF_CNT_EN defined, 4 stalls plus 2 redirects -> stall_count=4, flush_count=2. rst -> both 0.
